// File: rtl/grayscale.sv
// RGB-to-luminance front end: pops packed RGB pixels, computes floor((R+G+B)/3)
// through a two-stage stall-able pipe, pushes gray pixels and flags frame ends.
//
// Per-slot state (S1 and S2 each) | meaning
//   EMPTY (v=0)                   | slot holds a bubble
//   HOLD  (v=1, adv=0)            | slot holds a pixel, pipe stalled by gray_full
//   MOVE  (v=1, adv=1)            | slot holds a pixel that shifts on this edge
module grayscale #(
    parameter int IMG_WIDTH  = 540,
    parameter int IMG_HEIGHT = 720
) (
    input  logic        clock,
    input  logic        reset,
    output logic        rgb_rd_en,
    input  logic        rgb_empty,
    input  logic [23:0] rgb_dout,
    output logic        gray_wr_en,
    input  logic        gray_full,
    output logic [7:0]  gray_din,
    output logic        done
);

    localparam logic [19:0] LAST_PIX = 20'(IMG_WIDTH * IMG_HEIGHT - 1);

    logic        v1_q, v1_d;
    logic [9:0]  sum1_q, sum1_d;
    logic        v2_q, v2_d;
    logic [7:0]  q2_q, q2_d;
    logic [19:0] pix_cnt_q, pix_cnt_d;
    logic        done_q, done_d;
    logic        adv;

    // Exact restoring division by 3; the remainder never exceeds 2 and the
    // quotient of any sum up to 765 fits in 8 bits.
    function automatic logic [7:0] div3(input logic [9:0] n);
        logic [1:0] rem;
        logic [2:0] trial;
        logic [7:0] quo;
        rem = 2'd0;
        quo = 8'd0;
        for (int i = 9; i >= 0; i--) begin
            trial = {rem, n[i]};
            if (trial >= 3'd3) begin
                rem = 2'(trial - 3'd3);
                quo = {quo[6:0], 1'b1};
            end else begin
                rem = trial[1:0];
                quo = {quo[6:0], 1'b0};
            end
        end
        return quo;
    endfunction

    always_comb begin
        adv        = ~v2_q | ~gray_full;
        rgb_rd_en  = reset & ~rgb_empty & adv;
        gray_wr_en = reset & v2_q & ~gray_full;

        v1_d      = v1_q;
        sum1_d    = sum1_q;
        v2_d      = v2_q;
        q2_d      = q2_q;
        pix_cnt_d = pix_cnt_q;
        done_d    = 1'b0;

        if (adv) begin
            v2_d = v1_q;
            q2_d = div3(sum1_q);
            v1_d = rgb_rd_en;
            if (rgb_rd_en) begin
                sum1_d = {2'b00, rgb_dout[23:16]} + {2'b00, rgb_dout[15:8]}
                       + {2'b00, rgb_dout[7:0]};
            end
        end

        if (gray_wr_en) begin
            if (pix_cnt_q == LAST_PIX) begin
                pix_cnt_d = 20'd0;
                done_d    = 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + 20'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1_q      <= 1'b0;
            sum1_q    <= 10'd0;
            v2_q      <= 1'b0;
            q2_q      <= 8'd0;
            pix_cnt_q <= 20'd0;
            done_q    <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            sum1_q    <= sum1_d;
            v2_q      <= v2_d;
            q2_q      <= q2_d;
            pix_cnt_q <= pix_cnt_d;
            done_q    <= done_d;
        end
    end

    assign gray_din = q2_q;
    assign done     = done_q;

endmodule
